// File: rtl/mem_8_arbiter.sv
// ---------------------------------------------------------------------------
// mem_8_arbiter
//
// Shared 2^ADDR_W x DATA_W byte memory with two users: a host stream port
// (seekable, auto-incrementing pointer) and a local single-shot requester.
// Host traffic owns the memory by default (HOST state). A local request is
// granted for exactly one cycle (LCL state) after at least HOST_SLOTS-1 host
// cycles have elapsed since the previous local grant.
//
// Ports
//   bus_clk, bus_rst_n          clock, synchronous active-low reset
//   quiesce                     host link down, forces pointer to 0
//   user_r_mem_8_*              host read side  (rden/open in; empty/data/eof out)
//   user_w_mem_8_*              host write side (wren/data/open in; full out)
//   user_mem_8_addr(_update)    host seek
//   lcl_req/we/addr/wdata       local request, held stable until lcl_gnt
//   lcl_gnt, lcl_rdata, lcl_rvalid  local grant and read return
// ---------------------------------------------------------------------------
module mem_8_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int HOST_SLOTS = 4
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              quiesce,

    input  logic              user_r_mem_8_rden,
    output logic              user_r_mem_8_empty,
    output logic [DATA_W-1:0] user_r_mem_8_data,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open,

    input  logic              user_w_mem_8_wren,
    output logic              user_w_mem_8_full,
    input  logic [DATA_W-1:0] user_w_mem_8_data,
    input  logic              user_w_mem_8_open,

    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,

    input  logic              lcl_req,
    input  logic              lcl_we,
    input  logic [ADDR_W-1:0] lcl_addr,
    input  logic [DATA_W-1:0] lcl_wdata,
    output logic              lcl_gnt,
    output logic [DATA_W-1:0] lcl_rdata,
    output logic              lcl_rvalid
);

    typedef enum logic {ST_HOST, ST_LCL} state_t;

    localparam logic [3:0] SLOT_LAST = 4'(HOST_SLOTS - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0]   r_ptr,   w_ptr_nxt;

    logic                r_full;
    logic                r_empty;
    logic                r_gnt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_lcl_rdata;
    logic                r_lcl_rvalid;

    logic [DATA_W-1:0]   r_mem [0:(1 << ADDR_W) - 1];

    logic                w_host_wr, w_host_rd, w_lcl_act, w_lcl_wr, w_lcl_rd;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // The write side has no status that depends on whether the host has it open.
    logic                w_unused_w_open;
    assign w_unused_w_open = user_w_mem_8_open;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            r_state <= ST_HOST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: defaults at the top of every always_comb keep all paths assigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_HOST: begin
                if (lcl_req && (r_cnt >= SLOT_LAST)) begin
                    w_state_nxt = ST_LCL;
                end else if (r_cnt != 4'hF) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_LCL: begin
                w_state_nxt = ST_HOST;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_HOST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs / access decode ----------------
    // Host strobes seen during an LCL cycle are dropped entirely.
    always_comb begin
        w_lcl_act   = (r_state == ST_LCL);
        w_host_wr   = !w_lcl_act && user_w_mem_8_wren;
        w_host_rd   = !w_lcl_act && user_r_mem_8_rden;
        w_lcl_wr    = w_lcl_act && lcl_we;
        w_lcl_rd    = w_lcl_act && !lcl_we;
        w_mem_we    = w_host_wr || w_lcl_wr;
        w_mem_addr  = w_lcl_act ? lcl_addr  : r_ptr;
        w_mem_wdata = w_lcl_act ? lcl_wdata : user_w_mem_8_data;

        // quiesce beats seek, seek beats increment; the access itself used r_ptr.
        w_ptr_nxt = r_ptr;
        if (quiesce) begin
            w_ptr_nxt = '0;
        end else if (user_mem_8_addr_update) begin
            w_ptr_nxt = user_mem_8_addr;
        end else if (w_host_wr || w_host_rd) begin
            w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
    end

    // ---------------- datapath / registered outputs ----------------
    // Status flags are loaded from the next state so they line up with the LCL cycle.
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            r_ptr        <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_gnt        <= 1'b0;
            r_rdata      <= '0;
            r_lcl_rdata  <= '0;
            r_lcl_rvalid <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_full       <= (w_state_nxt == ST_LCL);
            r_gnt        <= (w_state_nxt == ST_LCL);
            r_empty      <= (w_state_nxt == ST_LCL) || !user_r_mem_8_open;
            r_lcl_rvalid <= w_lcl_rd;
            if (w_host_rd) begin
                r_rdata <= r_mem[w_mem_addr];
            end
            if (w_lcl_rd) begin
                r_lcl_rdata <= r_mem[w_mem_addr];
            end
        end
    end

    // NOTE: the memory array has no reset; contents survive bus_rst_n.
    always_ff @(posedge bus_clk) begin
        if (bus_rst_n && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign user_w_mem_8_full  = r_full;
    assign user_r_mem_8_empty = r_empty;
    assign user_r_mem_8_data  = r_rdata;
    assign user_r_mem_8_eof   = 1'b0;
    assign lcl_gnt            = r_gnt;
    assign lcl_rdata          = r_lcl_rdata;
    assign lcl_rvalid         = r_lcl_rvalid;

endmodule

// File: tb/tb_mem_8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_8_arbiter
//
// Drives mem_8_arbiter cycle by cycle. A behavioural model (byte array,
// integer pointer, count of host cycles since the last local grant) predicts
// every output after each edge. Directed scenarios additionally compare
// against fixed expected constants.
// ---------------------------------------------------------------------------
module tb_mem_8_arbiter;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 8;
    localparam int HOST_SLOTS = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              bus_clk = 1'b0;
    logic              bus_rst_n;
    logic              quiesce;
    logic              user_r_mem_8_rden;
    logic              user_r_mem_8_empty;
    logic [DATA_W-1:0] user_r_mem_8_data;
    logic              user_r_mem_8_eof;
    logic              user_r_mem_8_open;
    logic              user_w_mem_8_wren;
    logic              user_w_mem_8_full;
    logic [DATA_W-1:0] user_w_mem_8_data;
    logic              user_w_mem_8_open;
    logic [ADDR_W-1:0] user_mem_8_addr;
    logic              user_mem_8_addr_update;
    logic              lcl_req;
    logic              lcl_we;
    logic [ADDR_W-1:0] lcl_addr;
    logic [DATA_W-1:0] lcl_wdata;
    logic              lcl_gnt;
    logic [DATA_W-1:0] lcl_rdata;
    logic              lcl_rvalid;

    always #5 bus_clk = ~bus_clk;

    mem_8_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_SLOTS(HOST_SLOTS)
    ) dut (
        .bus_clk               (bus_clk),
        .bus_rst_n             (bus_rst_n),
        .quiesce               (quiesce),
        .user_r_mem_8_rden     (user_r_mem_8_rden),
        .user_r_mem_8_empty    (user_r_mem_8_empty),
        .user_r_mem_8_data     (user_r_mem_8_data),
        .user_r_mem_8_eof      (user_r_mem_8_eof),
        .user_r_mem_8_open     (user_r_mem_8_open),
        .user_w_mem_8_wren     (user_w_mem_8_wren),
        .user_w_mem_8_full     (user_w_mem_8_full),
        .user_w_mem_8_data     (user_w_mem_8_data),
        .user_w_mem_8_open     (user_w_mem_8_open),
        .user_mem_8_addr       (user_mem_8_addr),
        .user_mem_8_addr_update(user_mem_8_addr_update),
        .lcl_req               (lcl_req),
        .lcl_we                (lcl_we),
        .lcl_addr              (lcl_addr),
        .lcl_wdata             (lcl_wdata),
        .lcl_gnt               (lcl_gnt),
        .lcl_rdata             (lcl_rdata),
        .lcl_rvalid            (lcl_rvalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_ptr  = 0;
    bit                m_lcl  = 1'b0;   // current cycle is a local-grant cycle
    int                m_run  = 0;      // host cycles since last grant / reset
    logic              e_full, e_empty, e_gnt, e_lrv;
    logic [DATA_W-1:0] e_rdata, e_lrd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit cur;
        if (!bus_rst_n) begin
            m_lcl = 1'b0; m_run = 0; m_ptr = 0;
            e_full = 1'b0; e_empty = 1'b1; e_gnt = 1'b0;
            e_rdata = '0; e_lrd = '0; e_lrv = 1'b0;
        end else begin
            cur   = m_lcl;
            e_lrv = 1'b0;
            if (cur) begin
                if (lcl_we) m_mem[lcl_addr] = lcl_wdata;
                else begin
                    e_lrd = m_mem[lcl_addr];
                    e_lrv = 1'b1;
                end
            end else begin
                if (user_r_mem_8_rden) e_rdata = m_mem[m_ptr];
                if (user_w_mem_8_wren) m_mem[m_ptr] = user_w_mem_8_data;
            end
            if (quiesce) m_ptr = 0;
            else if (user_mem_8_addr_update) m_ptr = int'(user_mem_8_addr);
            else if (!cur && (user_w_mem_8_wren || user_r_mem_8_rden)) m_ptr = (m_ptr + 1) % DEPTH;

            if (cur) begin
                m_lcl = 1'b0;
                m_run = 0;
            end else if (lcl_req && m_run >= HOST_SLOTS - 1) begin
                m_lcl = 1'b1;
            end else begin
                m_run++;
            end
            e_full  = m_lcl;
            e_gnt   = m_lcl;
            e_empty = m_lcl || !user_r_mem_8_open;
        end
    endtask

    // One clock: predict, clock, then compare every output 1 time unit after the edge.
    task automatic cycle();
        model_edge();
        @(posedge bus_clk);
        #1;
        check("full",   32'(user_w_mem_8_full),  32'(e_full));
        check("empty",  32'(user_r_mem_8_empty), 32'(e_empty));
        check("gnt",    32'(lcl_gnt),            32'(e_gnt));
        check("eof",    32'(user_r_mem_8_eof),   32'(1'b0));
        check("rvalid", 32'(lcl_rvalid),         32'(e_lrv));
        check("lrdata", 32'(lcl_rdata),          32'(e_lrd));
        check("rdata",  32'(user_r_mem_8_data),  32'(e_rdata));
    endtask

    task automatic seek(input logic [ADDR_W-1:0] a);
        user_mem_8_addr_update = 1'b1;
        user_mem_8_addr        = a;
        cycle();
        user_mem_8_addr_update = 1'b0;
    endtask

    task automatic hwrite(input logic [DATA_W-1:0] d);
        user_w_mem_8_wren = 1'b1;
        user_w_mem_8_data = d;
        cycle();
        user_w_mem_8_wren = 1'b0;
    endtask

    task automatic hread();
        user_r_mem_8_rden = 1'b1;
        cycle();
        user_r_mem_8_rden = 1'b0;
    endtask

    // Clock until the current cycle is predicted to be a grant cycle (bounded).
    task automatic wait_lcl();
        int n = 0;
        while (!m_lcl && n < 20) begin
            cycle();
            n++;
        end
        check("lcl_wait_gnt", 32'(lcl_gnt), 32'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        bit served;
        int first_ok;

        bus_rst_n = 1'b0; quiesce = 1'b0;
        user_r_mem_8_rden = 1'b0; user_r_mem_8_open = 1'b1;
        user_w_mem_8_wren = 1'b0; user_w_mem_8_data = '0; user_w_mem_8_open = 1'b1;
        user_mem_8_addr = '0; user_mem_8_addr_update = 1'b0;
        lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = '0; lcl_wdata = '0;

        // Reset state
        cycle();
        cycle();
        check("rst_empty", 32'(user_r_mem_8_empty), 32'(1'b1));
        check("rst_full",  32'(user_w_mem_8_full),  32'(1'b0));
        bus_rst_n = 1'b1;

        // Fill memory so every later read has a known expectation
        seek(5'd0);
        for (int i = 0; i < DEPTH; i++) hwrite(8'($urandom));

        // Seek 3, write three bytes, read them back; pointer ends at 6
        seek(5'd3);
        hwrite(8'hA1); hwrite(8'hB2); hwrite(8'hC3);
        seek(5'd3);
        hread(); check("s028_rd0", 32'(user_r_mem_8_data), 32'h A1);
        hread(); check("s028_rd1", 32'(user_r_mem_8_data), 32'h B2);
        hread(); check("s028_rd2", 32'(user_r_mem_8_data), 32'h C3);
        hwrite(8'h77);
        seek(5'd6);
        hread(); check("s028_ptr6", 32'(user_r_mem_8_data), 32'h77);

        // Pointer wrap 31 -> 0
        seek(5'd31);
        hwrite(8'h55); hwrite(8'h66); hwrite(8'h11);
        seek(5'd31);
        hread(); check("s029_m31", 32'(user_r_mem_8_data), 32'h55);
        hread(); check("s029_m0",  32'(user_r_mem_8_data), 32'h66);
        hread(); check("s029_m1",  32'(user_r_mem_8_data), 32'h11);

        // Simultaneous write+read returns old value, single increment; seek wins over increment
        seek(5'd12);
        hwrite(8'h21);
        seek(5'd12);
        user_r_mem_8_rden = 1'b1; user_w_mem_8_wren = 1'b1; user_w_mem_8_data = 8'h9D;
        cycle();
        user_w_mem_8_wren = 1'b0;
        check("rw_old", 32'(user_r_mem_8_data), 32'h21);
        user_mem_8_addr_update = 1'b1; user_mem_8_addr = 5'd12;
        cycle();
        user_mem_8_addr_update = 1'b0;
        hread(); check("rw_new", 32'(user_r_mem_8_data), 32'h9D);

        // Local write then host read; local read with rvalid one cycle after gnt
        lcl_req = 1'b1; lcl_we = 1'b1; lcl_addr = 5'd7; lcl_wdata = 8'h3C;
        wait_lcl();
        cycle();
        lcl_req = 1'b0;
        seek(5'd7);
        hread(); check("s031_host", 32'(user_r_mem_8_data), 32'h3C);
        lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 5'd7;
        wait_lcl();
        cycle();
        lcl_req = 1'b0;
        check("s031_rvalid", 32'(lcl_rvalid), 32'(1'b1));
        check("s031_rdata",  32'(lcl_rdata),  32'h3C);
        cycle();
        check("s031_rv_low", 32'(lcl_rvalid), 32'(1'b0));

        // Host write during a grant cycle is ignored
        seek(5'd2);
        hwrite(8'h5A); hwrite(8'h4B);
        seek(5'd2);
        lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 5'd10;
        wait_lcl();
        user_w_mem_8_wren = 1'b1; user_w_mem_8_data = 8'hFF;
        cycle();
        user_w_mem_8_wren = 1'b0; lcl_req = 1'b0;
        hread(); check("s032_mem2", 32'(user_r_mem_8_data), 32'h5A);

        // Reset during a local-read grant cycle
        lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 5'd5;
        wait_lcl();
        bus_rst_n = 1'b0;
        cycle();
        check("s033_rvalid", 32'(lcl_rvalid),         32'(1'b0));
        check("s033_empty",  32'(user_r_mem_8_empty), 32'(1'b1));
        check("s033_full",   32'(user_w_mem_8_full),  32'(1'b0));
        bus_rst_n = 1'b1; lcl_req = 1'b0;
        hread(); check("s033_ptr0", 32'(user_r_mem_8_data), 32'h66);

        // Continuous request: grant every 5th cycle, full/empty only then
        bus_rst_n = 1'b0;
        cycle();
        bus_rst_n = 1'b1;
        lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 5'd9;
        first_ok = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (lcl_gnt) begin
                first_ok = 1;
                break;
            end
        end
        check("s030_first", 32'(first_ok), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("s030_gnt",   32'(lcl_gnt),            32'((k % 5) == 0));
            check("s030_full",  32'(user_w_mem_8_full),  32'((k % 5) == 0));
            check("s030_empty", 32'(user_r_mem_8_empty), 32'((k % 5) == 0));
        end
        lcl_req = 1'b0;

        // Quiesce overrides a seek
        user_mem_8_addr_update = 1'b1; user_mem_8_addr = 5'd9; quiesce = 1'b1;
        cycle();
        user_mem_8_addr_update = 1'b0; quiesce = 1'b0;
        hread(); check("quiesce_ptr0", 32'(user_r_mem_8_data), 32'h66);

        // Randomized traffic against the model
        pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bus_rst_n = ($urandom % 150) != 0;
            if (!pend && ($urandom % 4) == 0) begin
                pend      = 1'b1;
                lcl_we    = 1'($urandom % 2);
                lcl_addr  = 5'($urandom);
                lcl_wdata = 8'($urandom);
            end else if (pend && !m_lcl && ($urandom % 12) == 0) begin
                pend = 1'b0;
            end
            lcl_req                = pend;
            user_w_mem_8_wren      = ($urandom % 3) == 0;
            user_r_mem_8_rden      = ($urandom % 3) == 0;
            user_w_mem_8_data      = 8'($urandom);
            user_mem_8_addr_update = ($urandom % 8) == 0;
            user_mem_8_addr        = 5'($urandom);
            quiesce                = ($urandom % 16) == 0;
            user_r_mem_8_open      = ($urandom % 8) != 0;
            user_w_mem_8_open      = ($urandom % 8) != 0;
            served = m_lcl;
            cycle();
            if (served) pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_8_arbiter.md
MEM_8_ARBITER -- requirements
Module: mem_8_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, address width (32 bytes); DATA_W, 8, byte width; HOST_SLOTS, 4, minimum HOST-state cycles between local grants (range 1..15).
REQ-002 Ports SHALL be: bus_clk  in  1  sole clock, all logic rising-edge.
REQ-003 bus_rst_n  in  1  reset, synchronous, active-low.
REQ-004 quiesce  in  1  host link down; while high, address pointer is forced to 0.
REQ-005 user_r_mem_8_rden  in  1; user_r_mem_8_empty  out  1; user_r_mem_8_data  out  DATA_W; user_r_mem_8_eof  out  1; user_r_mem_8_open  in  1  host read side.
REQ-006 user_w_mem_8_wren  in  1; user_w_mem_8_full  out  1; user_w_mem_8_data  in  DATA_W; user_w_mem_8_open  in  1  host write side.
REQ-007 user_mem_8_addr  in  ADDR_W; user_mem_8_addr_update  in  1  host seek.
REQ-008 lcl_req  in  1; lcl_we  in  1; lcl_addr  in  ADDR_W; lcl_wdata  in  DATA_W; lcl_gnt  out  1; lcl_rdata  out  DATA_W; lcl_rvalid  out  1  local requester.

Function
REQ-009 Block SHALL own a 2^ADDR_W x DATA_W single-access memory shared by host and local port; one access per cycle.
REQ-010 FSM SHALL have states HOST and LCL; reset state HOST.
REQ-011 HOST->LCL SHALL occur when lcl_req=1 and slot counter >= HOST_SLOTS-1; otherwise stay HOST, counter saturating increment.
REQ-012 LCL SHALL last exactly one cycle, then return to HOST with counter cleared to 0.
REQ-013 user_w_mem_8_full SHALL be registered, 1 exactly during LCL cycles, else 0.
REQ-014 user_r_mem_8_empty SHALL be registered, 1 during LCL cycles or when user_r_mem_8_open was 0 the previous cycle, else 0.
REQ-015 user_r_mem_8_eof SHALL be constant 0.
REQ-016 Pointer: user_mem_8_addr_update=1 loads user_mem_8_addr; else any accepted host wren or rden increments by 1, modulo 2^ADDR_W (31->0).
REQ-017 Host write: wren in HOST writes user_w_mem_8_data to mem[pointer] same edge.
REQ-018 Host read: rden in HOST SHALL set user_r_mem_8_data = mem[pointer] on the next cycle (1-cycle latency); data held until next rden.
REQ-019 Simultaneous wren and rden: write mem[pointer], read returns pre-write value, pointer increments once.
REQ-020 addr_update with wren/rden same cycle: access uses old pointer; load wins over increment.
REQ-021 wren/rden during LCL are protocol violations and SHALL be ignored (no memory/pointer change).
REQ-022 lcl_gnt SHALL pulse 1 for the LCL cycle; local access executes that cycle at lcl_addr; lcl_req/lcl_we/lcl_addr/lcl_wdata held stable by requester until gnt.
REQ-023 Local read (lcl_we=0): lcl_rdata = mem[lcl_addr] and lcl_rvalid=1 the cycle after gnt; lcl_rvalid 0 otherwise; lcl_rdata held.
REQ-024 quiesce=1 forces pointer to 0 (over addr_update); FSM and pending local requests continue.
REQ-025 lcl_req dropped before grant SHALL be treated as withdrawn (no access).

Reset
REQ-026 bus_rst_n=0 at a clock edge SHALL set: state HOST, counter 0, pointer 0, user_w_mem_8_full 0, user_r_mem_8_empty 1, user_r_mem_8_data 0, lcl_gnt 0, lcl_rdata 0, lcl_rvalid 0.
REQ-027 Memory contents SHALL NOT be cleared by reset; reset mid-LCL aborts the pending lcl_rvalid.

Verification
REQ-028 Seek addr=3, host writes 0xA1,0xB2,0xC3, seek 3, three rdens -> data 0xA1,0xB2,0xC3 each one cycle after rden; pointer ends 6.
REQ-029 Seek 31, write 0x55,0x66 -> mem[31]=0x55, mem[0]=0x66, pointer 1.
REQ-030 lcl_req held continuously, HOST_SLOTS=4 -> lcl_gnt every 5th cycle; full=1 and empty=1 only in those cycles.
REQ-031 Local write addr 7 data 0x3C, then host seek 7 + rden -> host reads 0x3C; local read addr 7 -> lcl_rvalid one cycle after gnt with 0x3C.
REQ-032 wren forced during LCL with data 0xFF at pointer 2 -> mem[2] unchanged, pointer stays 2.
REQ-033 Reset asserted in LCL cycle with local read -> next cycle lcl_rvalid=0, empty=1, full=0, pointer 0.
